ahb_arb_top: RTL and testbench

Round-robin AHB bus arbiter that shares one AHB address/data path between up to four masters. It sits in the AHB matrix beside the master mux. It produces per-master grants plus the address-phase and data-phase owner IDs that steer the address and write-data muxes. It honours fixed-length bursts, locked transfers and wait states, and parks the bus on a default master when no master requests it.

---
 rtl/ahb_arb_top.sv | 114 +++++++++++
 tb/tb_ahb_arb_top.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arb_top.sv
// Round-robin AHB arbiter for up to four masters: registered grant, address/data-phase
// owner indices and lock flag, with burst-length and lock based grant holding.
module ahb_arb_top #(
    parameter int unsigned NUM_MST = 3,
    parameter int unsigned DEF_MST = 0
) (
    input  logic               hclk,
    input  logic               hrst_b,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    output logic [NUM_MST-1:0] hgrant,
    output logic [1:0]         hmaster,
    output logic [1:0]         hmaster_d,
    output logic               hmastlock
);
    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    localparam logic [NUM_MST-1:0] GNT_RST = NUM_MST'(1) << DEF_MST;
    localparam logic [1:0]         MST_RST = 2'(DEF_MST);

    logic [NUM_MST-1:0] grant_q, grant_d, win_oh;
    logic [1:0]         mst_q, mstd_q, gnt_idx;
    logic               lock_q, gnt_lock, own_lock, hold, found;
    logic [4:0]         cnt_q, cnt_d, len, rem;
    htrans_e            trans;

    assign trans = htrans_e'(htrans);

    always_comb begin
        case (hburst)
            3'b000, 3'b001: len = 5'd1;
            3'b010, 3'b011: len = 5'd4;
            3'b100, 3'b101: len = 5'd8;
            default:        len = 5'd16;
        endcase
    end

    always_comb begin
        rem   = '0;
        cnt_d = cnt_q;
        case (trans)
            TR_NONSEQ: begin
                rem   = len;
                cnt_d = len - 5'd1;
            end
            TR_SEQ: begin
                rem   = cnt_q;
                cnt_d = (cnt_q != '0) ? cnt_q - 5'd1 : cnt_q;
            end
            TR_BUSY: rem = cnt_q;
            default: cnt_d = '0;
        endcase
    end

    always_comb begin
        own_lock = 1'b0;
        gnt_idx  = '0;
        gnt_lock = 1'b0;
        for (int unsigned i = 0; i < NUM_MST; i++) begin
            if (mst_q == 2'(i)) own_lock = hlock[i];
            if (grant_q[i]) begin
                gnt_idx  = 2'(i);
                gnt_lock = hlock[i];
            end
        end
    end

    // Offset k=1 is the master after the current owner; the owner itself (k=NUM_MST) is last.
    always_comb begin
        win_oh = GNT_RST;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            for (int unsigned j = 0; j < NUM_MST; j++) begin
                if (!found && hbusreq[j] && (j == (32'(mst_q) + k) % NUM_MST)) begin
                    win_oh    = '0;
                    win_oh[j] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign hold    = own_lock | (rem >= 5'd3);
    assign grant_d = hold ? grant_q : win_oh;

    always_ff @(posedge hclk or negedge hrst_b) begin
        if (!hrst_b) begin
            grant_q <= GNT_RST;
            mst_q   <= MST_RST;
            mstd_q  <= MST_RST;
            lock_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (hready) begin
            grant_q <= grant_d;
            mst_q   <= gnt_idx;
            mstd_q  <= mst_q;
            lock_q  <= gnt_lock;
            cnt_q   <= cnt_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = mst_q;
    assign hmaster_d = mstd_q;
    assign hmastlock = lock_q;
endmodule

// File: tb/tb_ahb_arb_top.sv
// Bench for ahb_arb_top: vector table, burst/lock/reset sequences and a randomized run
// against an integer-level model of the arbitration rules.
module tb_ahb_arb_top;
    localparam int unsigned NUM_MST = 3;
    localparam int unsigned DEF_MST = 0;

    logic       hclk   = 1'b0;
    logic       hrst_b = 1'b1;
    logic [2:0] hbusreq = '0;
    logic [2:0] hlock   = '0;
    logic [1:0] htrans  = '0;
    logic [2:0] hburst  = '0;
    logic       hready  = 1'b1;
    logic [2:0] hgrant;
    logic [1:0] hmaster, hmaster_d;
    logic       hmastlock;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_arb_top #(.NUM_MST(NUM_MST), .DEF_MST(DEF_MST)) dut (
        .hclk      (hclk),
        .hrst_b    (hrst_b),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmaster_d (hmaster_d),
        .hmastlock (hmastlock)
    );

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] lck;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [2:0] g;
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g, input logic [1:0] m,
                           input logic [1:0] md, input logic ml);
        chk({tag, ".hgrant"},    32'(hgrant),    32'(g));
        chk({tag, ".hmaster"},   32'(hmaster),   32'(m));
        chk({tag, ".hmaster_d"}, 32'(hmaster_d), 32'(md));
        chk({tag, ".hmastlock"}, 32'(hmastlock), 32'(ml));
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] lck, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
    endtask

    task automatic do_reset();
        drive(3'b000, 3'b000, 2'b00, 3'b000, 1'b1);
        hrst_b = 1'b0;
        @(negedge hclk);
        hrst_b = 1'b1;
    endtask

    // M1 runs an INCR4 while M2 requests; beat 2 is stretched by 'waits' wait states.
    task automatic run_incr4(input int waits);
        int edges;
        int handover;
        do_reset();
        drive(3'b010, 3'b000, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        chk_all("incr4.setup", 3'b010, 2'd1, 2'd0, 1'b0);
        edges    = 0;
        handover = -1;
        for (int b = 1; b <= 4; b++) begin
            drive(3'b110, 3'b000, (b == 1) ? 2'b10 : 2'b11, 3'b011, 1'b1);
            if (b == 2) begin
                for (int w = 0; w < waits; w++) begin
                    hready = 1'b0;
                    tick();
                    edges++;
                    if (hgrant == 3'b100 && handover < 0) handover = edges;
                    chk_all("incr4.wait", 3'b010, 2'd1, 2'd1, 1'b0);
                end
                hready = 1'b1;
            end
            tick();
            edges++;
            if (hgrant == 3'b100 && handover < 0) handover = edges;
            case (b)
                1: chk_all("incr4.beat1", 3'b010, 2'd1, 2'd1, 1'b0);
                2: chk_all("incr4.beat2", 3'b010, 2'd1, 2'd1, 1'b0);
                3: chk_all("incr4.beat3", 3'b100, 2'd1, 2'd1, 1'b0);
                default: chk_all("incr4.beat4", 3'b100, 2'd2, 2'd1, 1'b0);
            endcase
        end
        chk("incr4.handover_edge", 32'(handover), 32'(3 + waits));
    endtask

    int mg, mo, md, ml, mc, rem, win, j;
    bit hold;

    function automatic int blen(input logic [2:0] b);
        if (b < 3'd2) return 1;
        return 4 << ((int'(b) - 2) / 2);
    endfunction

    initial begin
        // req, lck, tr, bu, rdy | hgrant, hmaster, hmaster_d, hmastlock
        tbl[0]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b010, 2'd1, 2'd0, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b100, 2'd1, 2'd1, 1'b0};
        tbl[3]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b100, 2'd2, 2'd1, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0};
        tbl[6]  = '{3'b111, 3'b000, 2'b10, 3'b000, 1'b0, 3'b001, 2'd0, 2'd2, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 2'b00, 3'b000, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0};
        tbl[8]  = '{3'b100, 3'b000, 2'b00, 3'b000, 1'b1, 3'b100, 2'd0, 2'd0, 1'b0};
        tbl[9]  = '{3'b100, 3'b000, 2'b00, 3'b000, 1'b1, 3'b100, 2'd2, 2'd0, 1'b0};
        tbl[10] = '{3'b000, 3'b000, 2'b00, 3'b000, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 2'b00, 3'b000, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0};
        tbl[12] = '{3'b010, 3'b010, 2'b00, 3'b000, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0};
        tbl[13] = '{3'b010, 3'b010, 2'b00, 3'b000, 1'b1, 3'b010, 2'd1, 2'd0, 1'b1};
        tbl[14] = '{3'b001, 3'b010, 2'b00, 3'b000, 1'b1, 3'b010, 2'd1, 2'd1, 1'b1};
        tbl[15] = '{3'b001, 3'b000, 2'b00, 3'b000, 1'b1, 3'b001, 2'd1, 2'd1, 1'b0};

        #1 hrst_b = 1'b0;
        #2 chk_all("reset", 3'b001, 2'd0, 2'd0, 1'b0);
        @(negedge hclk);
        hrst_b = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].req, tbl[i].lck, tbl[i].tr, tbl[i].bu, tbl[i].rdy);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].m, tbl[i].md, tbl[i].ml);
        end

        run_incr4(0);
        run_incr4(3);

        do_reset();
        drive(3'b100, 3'b000, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        chk_all("lock.setup", 3'b100, 2'd2, 2'd0, 1'b0);
        drive(3'b101, 3'b100, 2'b00, 3'b000, 1'b1);
        tick();
        chk_all("lock.held1", 3'b100, 2'd2, 2'd2, 1'b1);
        tick();
        chk_all("lock.held2", 3'b100, 2'd2, 2'd2, 1'b1);
        hlock = 3'b000;
        tick();
        chk_all("lock.drop", 3'b001, 2'd2, 2'd2, 1'b0);
        tick();
        chk_all("lock.newown", 3'b001, 2'd0, 2'd2, 1'b0);

        do_reset();
        drive(3'b010, 3'b000, 2'b00, 3'b000, 1'b1);
        tick();
        tick();
        drive(3'b010, 3'b000, 2'b10, 3'b011, 1'b1);
        tick();
        chk_all("rstburst.beat1", 3'b010, 2'd1, 2'd1, 1'b0);
        htrans = 2'b11;
        #3 hrst_b = 1'b0;
        #1 chk_all("rstburst.async", 3'b001, 2'd0, 2'd0, 1'b0);
        #1 hrst_b = 1'b1;
        tick();
        chk_all("rstburst.cnt_cleared", 3'b010, 2'd0, 2'd0, 1'b0);

        do_reset();
        mg = DEF_MST; mo = DEF_MST; md = DEF_MST; ml = 0; mc = 0;
        for (int n = 0; n < 3000; n++) begin
            hbusreq = 3'($urandom_range(0, 7));
            for (int b = 0; b < 3; b++) hlock[b] = ($urandom_range(0, 3) == 0);
            htrans  = 2'($urandom_range(0, 3));
            hburst  = 3'($urandom_range(0, 7));
            hready  = ($urandom_range(0, 3) != 0);
            if (hready) begin
                if (htrans == 2'b10)      rem = blen(hburst);
                else if (htrans == 2'b00) rem = 0;
                else                      rem = mc;
                hold = hlock[mo] || (rem >= 3);
                win  = DEF_MST;
                for (int k = NUM_MST; k >= 1; k--) begin
                    j = (mo + k) % NUM_MST;
                    if (hbusreq[j]) win = j;
                end
                md = mo;
                mo = mg;
                ml = int'(hlock[mg]);
                if (!hold) mg = win;
                if (htrans == 2'b10)                mc = blen(hburst) - 1;
                else if (htrans == 2'b11 && mc > 0) mc = mc - 1;
                else if (htrans == 2'b00)           mc = 0;
            end
            tick();
            chk_all("rand", 3'(1 << mg), 2'(mo), 2'(md), ml[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
